// File: rtl/alu_result_checker.sv
// Self-checking harness for a 2-bit-opcode ALU.
// Each accepted vector's expected result is compared against F one cycle later.
// Pass/fail counts and the first mismatch are kept for the run.
module alu_result_checker #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] num_vectors,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  F,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [CW-1:0] first_fail_idx,
  output logic [N-1:0]  first_fail_exp,
  output logic [N-1:0]  first_fail_got
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_num_vectors;
  logic [CW-1:0] r_vec_idx;
  logic [CW-1:0] r_pass_cnt;
  logic [CW-1:0] r_fail_cnt;
  logic [CW-1:0] r_ff_idx;
  logic [N-1:0]  r_ff_exp;
  logic [N-1:0]  r_ff_got;

  // One-stage compare pipeline
  logic          r_cmp_valid;
  logic          r_cmp_match;
  logic [CW-1:0] r_cmp_idx;
  logic [N-1:0]  r_cmp_exp;
  logic [N-1:0]  r_cmp_got;

  logic          w_accept;
  logic [CW-1:0] w_idx_next;
  logic [N-1:0]  w_expected;

  assign w_accept   = in_valid && (r_state == StRun);
  assign w_idx_next = r_vec_idx + 1'b1;

  // Reference ALU model; the add drops the carry out of the top bit.
  always_comb begin
    w_expected = '0;
    unique case (op)
      2'b00: w_expected = ~A;
      2'b01: w_expected = A & B;
      2'b10: w_expected = A | B;
      2'b11: w_expected = A + B;
      default: w_expected = '0;
    endcase
  end

  // Run control, compare pipeline, saturating counters and first-fail capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_num_vectors <= '0;
      r_vec_idx     <= '0;
      r_pass_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_ff_idx      <= '0;
      r_ff_exp      <= '0;
      r_ff_got      <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_match   <= 1'b0;
      r_cmp_idx     <= '0;
      r_cmp_exp     <= '0;
      r_cmp_got     <= '0;
    end else begin
      r_cmp_valid <= w_accept;
      if (w_accept) begin
        r_cmp_match <= (F == w_expected);
        r_cmp_idx   <= r_vec_idx;
        r_cmp_exp   <= w_expected;
        r_cmp_got   <= F;
        r_vec_idx   <= w_idx_next;
      end

      if (r_cmp_valid) begin
        if (r_cmp_match) begin
          if (r_pass_cnt != {CW{1'b1}}) r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          if (r_fail_cnt != {CW{1'b1}}) r_fail_cnt <= r_fail_cnt + 1'b1;
          // fail_cnt never wraps, so zero means no mismatch seen yet this run
          if (r_fail_cnt == '0) begin
            r_ff_idx <= r_cmp_idx;
            r_ff_exp <= r_cmp_exp;
            r_ff_got <= r_cmp_got;
          end
        end
      end

      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_num_vectors <= num_vectors;
            r_vec_idx     <= '0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_ff_idx      <= '0;
            r_ff_exp      <= '0;
            r_ff_got      <= '0;
            r_state       <= (num_vectors == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (w_accept && (w_idx_next == r_num_vectors)) r_state <= StFlush;
        end
        StFlush: r_state <= StDone;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready       = (r_state == StRun);
  assign busy           = (r_state == StRun) || (r_state == StFlush);
  assign done           = (r_state == StDone);
  assign pass           = (r_state == StDone) && (r_fail_cnt == '0);
  assign pass_cnt       = r_pass_cnt;
  assign fail_cnt       = r_fail_cnt;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_exp = r_ff_exp;
  assign first_fail_got = r_ff_got;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: each run pushes its expected summary,
// and the monitor compares it when the checker reaches DONE.
module tb_alu_result_checker;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [N-1:0]  A, B, F;
  logic          busy, done, pass;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [N-1:0]  first_fail_exp, first_fail_got;

  alu_result_checker #(.N(N), .CW(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_vectors    (num_vectors),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op             (op),
    .A              (A),
    .B              (B),
    .F              (F),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_exp (first_fail_exp),
    .first_fail_got (first_fail_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pass;
    logic [CW-1:0] pc;
    logic [CW-1:0] fc;
    logic [CW-1:0] ffi;
    logic [N-1:0]  ffe;
    logic [N-1:0]  ffg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_accepts = 0;
  bit   seen_ready = 1'b0;
  bit   armed = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic p, input int pc, input int fc, input int ffi,
                          input logic [N-1:0] ffe, input logic [N-1:0] ffg);
    exp_t e;
    e.pass = p;
    e.pc   = CW'(pc);
    e.fc   = CW'(fc);
    e.ffi  = CW'(ffi);
    e.ffe  = ffe;
    e.ffg  = ffg;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic start_run(input int n);
    start       = 1'b1;
    num_vectors = CW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] f);
    int t;
    op = o;
    A  = a;
    B  = b;
    F  = f;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL done_timeout: done stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_pass"},     64'(pass),     64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'd0);
    check({tag, "_ff_idx"},   64'(first_fail_idx), 64'd0);
    check({tag, "_ff_exp"},   64'(first_fail_exp), 64'd0);
    check({tag, "_ff_got"},   64'(first_fail_got), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_vectors = '0;
    in_valid = 1'b0;
    op = 2'b00;
    A = '0;
    B = '0;
    F = '0;
    fork
      // Monitor: arms when a start will be accepted, compares when DONE is reached.
      forever begin
        exp_t e;
        @(negedge clk);
        if (in_ready) seen_ready = 1'b1;
        if (in_valid && in_ready) n_accepts++;
        if (done && armed) begin
          armed = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_empty: done seen, expected no result");
          end else begin
            e = exp_q.pop_front();
            check("sb_pass",     64'(pass),           64'(e.pass));
            check("sb_pass_cnt", 64'(pass_cnt),       64'(e.pc));
            check("sb_fail_cnt", 64'(fail_cnt),       64'(e.fc));
            check("sb_ff_idx",   64'(first_fail_idx), 64'(e.ffi));
            check("sb_ff_exp",   64'(first_fail_exp), 64'(e.ffe));
            check("sb_ff_got",   64'(first_fail_got), 64'(e.ffg));
          end
        end
        if (start && !busy && !reset) armed = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");

        // All-NOT run, all correct.
        push_exp(1'b1, 5, 0, 0, 32'h0, 32'h0);
        start_run(5);
        send_vec(2'b00, 32'd0,    32'd0, 32'hFFFF_FFFF);
        send_vec(2'b00, 32'd14,   32'd0, 32'hFFFF_FFF1);
        send_vec(2'b00, 32'd1,    32'd0, 32'hFFFF_FFFE);
        send_vec(2'b00, 32'd180,  32'd0, 32'hFFFF_FF4B);
        send_vec(2'b00, 32'd1543, 32'd0, 32'hFFFF_F9F8);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("hold_done",     64'(done),     64'd1);
        check("hold_pass_cnt", 64'(pass_cnt), 64'd5);

        // Single mismatch at index 2 (AND).
        push_exp(1'b0, 3, 1, 2, 32'hF000_F000, 32'hF0F0_F0F1);
        start_run(4);
        send_vec(2'b11, 32'hFFFF_FFFF, 32'h1,         32'h0);
        send_vec(2'b10, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        send_vec(2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F1);
        send_vec(2'b00, 32'h0,         32'h0,         32'hFFFF_FFFF);
        wait_done();

        // Mismatches at 1 and 3; the first must be retained.
        push_exp(1'b0, 2, 2, 1, 32'h3, 32'h4);
        start_run(4);
        send_vec(2'b11, 32'd2, 32'd3, 32'd5);
        send_vec(2'b10, 32'd1, 32'd2, 32'd4);
        send_vec(2'b01, 32'd6, 32'd3, 32'd2);
        send_vec(2'b11, 32'd7, 32'd8, 32'd0);
        wait_done();

        // Empty run from DONE: DONE again after one cycle, in_ready never raised.
        seen_ready = 1'b0;
        push_exp(1'b1, 0, 0, 0, 32'h0, 32'h0);
        start_run(0);
        check("zero_done_next", 64'(done), 64'd1);
        check("zero_busy",      64'(busy), 64'd0);
        wait_done();
        check("zero_no_ready",  64'(seen_ready), 64'd0);

        // Reset after two accepts; the in-flight mismatch must be discarded.
        start_run(5);
        send_vec(2'b11, 32'd1, 32'd1, 32'd2);
        send_vec(2'b01, 32'hF, 32'h3, 32'h7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("midrun_reset");
        push_exp(1'b1, 1, 0, 0, 32'h0, 32'h0);
        start_run(1);
        send_vec(2'b11, 32'd10, 32'd20, 32'd30);
        wait_done();

        // Gapped in_valid with a stray start during RUN.
        n_accepts = 0;
        push_exp(1'b1, 3, 0, 0, 32'h0, 32'h0);
        start_run(3);
        send_vec(2'b01, 32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_00FF);
        start = 1'b1;
        num_vectors = CW'(7);
        @(posedge clk);
        #1;
        start = 1'b0;
        send_vec(2'b10, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        @(posedge clk);
        #1;
        send_vec(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0);
        @(posedge clk);
        #1;
        wait_done();
        check("gap_accepts", 64'(n_accepts), 64'd3);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    join_any
  end

endmodule
